instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded MIPS-style instruction fields, packs
// them into a 32-bit word and writes that word to sequential instruction-memory
// addresses. It accepts one instruction every two cycles. It stops in DONE
// after the instruction flagged 'last' and stops in FULL when address 255 has
// been written without 'last'.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [1:0]  instType,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic        last,
  input  logic        restart,
  output logic        memWriteEn,
  output logic [7:0]  memAddr,
  output logic [31:0] memData,
  output logic [8:0]  count,
  output logic        done,
  output logic        full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t state_r;
  state_t nextState_s;
  logic   accept_s;
  logic   last_r;
  logic   lastAddr_s;

  // Map the 2-bit instruction type onto the 6-bit opcode field.
  function automatic logic [5:0] opcodeOf(input logic [1:0] t);
    logic [5:0] op;
    case (t)
      2'b00:   op = 6'b000000; // R-type
      2'b01:   op = 6'b100011; // lw
      2'b10:   op = 6'b101011; // sw
      2'b11:   op = 6'b000100; // beq
      default: op = 6'b000000;
    endcase
    return op;
  endfunction

  // Pack the fields into an instruction word; I-type ignores rd/shamt/funct.
  function automatic logic [31:0] encodeInstr(
    input logic [1:0]  t,
    input logic [4:0]  fRs,
    input logic [4:0]  fRt,
    input logic [4:0]  fRd,
    input logic [4:0]  fShamt,
    input logic [5:0]  fFunct,
    input logic [15:0] fImm
  );
    logic [31:0] word;
    if (t == 2'b00) begin
      word = {opcodeOf(t), fRs, fRt, fRd, fShamt, fFunct};
    end else begin
      word = {opcodeOf(t), fRs, fRt, fImm};
    end
    return word;
  endfunction

  // Restart wins over a coincident accept, so the accept is dropped.
  assign accept_s   = (state_r == IDLE) && inValid && inReady && !restart;
  assign lastAddr_s = (memAddr == 8'd255);

  // Next-state logic; restart overrides every transition.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          nextState_s = WRITE;
        end else begin
          nextState_s = IDLE;
        end
      end
      WRITE: begin
        // 'last' takes precedence, so a final write at 255 ends in DONE.
        if (last_r) begin
          nextState_s = DONE;
        end else if (lastAddr_s) begin
          nextState_s = FULL;
        end else begin
          nextState_s = IDLE;
        end
      end
      DONE:    nextState_s = DONE;
      FULL:    nextState_s = FULL;
      default: nextState_s = IDLE;
    endcase
    if (restart) begin
      nextState_s = IDLE;
    end else begin
      nextState_s = nextState_s;
    end
  end

  // State register and registered outputs; reset dominates restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      inReady    <= 1'b1;
      memWriteEn <= 1'b0;
      memData    <= 32'd0;
      memAddr    <= 8'd0;
      count      <= 9'd0;
      done       <= 1'b0;
      full       <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      inReady    <= (nextState_s == IDLE);
      memWriteEn <= accept_s;
      // The word is captured only at accept and is zero outside the write cycle.
      memData    <= accept_s ? encodeInstr(instType, rs, rt, rd, shamt, funct, imm) : 32'd0;
      last_r     <= accept_s ? last : last_r;
      if (restart) begin
        // A write already in flight this cycle completes before the clear.
        memAddr <= 8'd0;
        count   <= 9'd0;
        done    <= 1'b0;
        full    <= 1'b0;
      end else if (state_r == WRITE) begin
        count   <= count + 9'd1;
        // Address saturates at 255; FULL stops further writes.
        memAddr <= lastAddr_s ? memAddr : memAddr + 8'd1;
        done    <= last_r;
        full    <= !last_r && lastAddr_s;
      end else begin
        memAddr <= memAddr;
        count   <= count;
        done    <= done;
        full    <= full;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [1:0]  instType;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        last;
  logic        restart;
  logic        memWriteEn;
  logic [7:0]  memAddr;
  logic [31:0] memData;
  logic [8:0]  count;
  logic        done;
  logic        full;

  int checks   = 0;
  int failures = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .instType(instType), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .last(last), .restart(restart),
    .memWriteEn(memWriteEn), .memAddr(memAddr), .memData(memData),
    .count(count), .done(done), .full(full)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setFields(input logic [1:0] t, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] s, input logic [5:0] f,
                           input logic [15:0] i, input logic l);
    instType = t; rs = a; rt = b; rd = c; shamt = s; funct = f; imm = i; last = l;
  endtask

  task automatic doReset();
    reset = 1'b1; inValid = 1'b0; restart = 1'b0;
    setFields(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b0; restart = 1'b0;
    setFields(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
    tick();
    checks++;
    if ({inReady, memWriteEn, memAddr, memData, count, done, full} !== {1'b1, 1'b0, 8'd0, 32'd0, 9'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got inReady=%b we=%b addr=%0d data=%h count=%0d done=%b full=%b, want 1 0 0 0 0 0 0",
               inReady, memWriteEn, memAddr, memData, count, done, full);
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    doReset();
    setFields(2'b00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h1234, 1'b0);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    // Fields change after accept; the write must not see them.
    setFields(2'b11, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b1);
    checks++;
    if (memWriteEn !== 1'b1 || memData !== 32'h00221820 || memAddr !== 8'd0) begin
      failures++;
      $display("FAIL rtype_write: got we=%b data=%h addr=%0d, want 1 00221820 0", memWriteEn, memData, memAddr);
    end
    tick();
    checks++;
    if (memWriteEn !== 1'b0 || memData !== 32'd0 || memAddr !== 8'd1 || count !== 9'd1 || inReady !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rtype_after: got we=%b data=%h addr=%0d count=%0d inReady=%b done=%b, want 0 0 1 1 1 0",
               memWriteEn, memData, memAddr, count, inReady, done);
    end
  endtask

  task automatic test_lw_last();
    doReset();
    setFields(2'b01, 5'd9, 5'd8, 5'd7, 5'd6, 6'd5, 16'd4, 1'b1);
    inValid = 1'b1;
    tick();
    checks++;
    if (memWriteEn !== 1'b1 || memData !== 32'h8D280004 || memAddr !== 8'd0 || inReady !== 1'b0) begin
      failures++;
      $display("FAIL lw_write: got we=%b data=%h addr=%0d inReady=%b, want 1 8D280004 0 0", memWriteEn, memData, memAddr, inReady);
    end
    // inValid stays high: nothing further may be accepted in DONE.
    setFields(2'b00, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 1'b0);
    tick();
    checks++;
    if (done !== 1'b1 || full !== 1'b0 || inReady !== 1'b0 || memWriteEn !== 1'b0 || count !== 9'd1) begin
      failures++;
      $display("FAIL lw_done: got done=%b full=%b inReady=%b we=%b count=%0d, want 1 0 0 0 1", done, full, inReady, memWriteEn, count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (memWriteEn !== 1'b0 || inReady !== 1'b0 || done !== 1'b1 || memData !== 32'd0) begin
        failures++;
        $display("FAIL done_hold: cycle %0d got we=%b inReady=%b done=%b data=%h, want 0 0 1 0", i, memWriteEn, inReady, done, memData);
      end
    end
    inValid = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (done !== 1'b0 || count !== 9'd0 || memAddr !== 8'd0 || inReady !== 1'b1 || memWriteEn !== 1'b0) begin
      failures++;
      $display("FAIL done_restart: got done=%b count=%0d addr=%0d inReady=%b we=%b, want 0 0 0 1 0", done, count, memAddr, inReady, memWriteEn);
    end
  endtask

  task automatic test_beq_sw();
    doReset();
    setFields(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'hFFFF, 1'b0);
    inValid = 1'b1;
    tick();
    checks++;
    if (memWriteEn !== 1'b1 || memData !== 32'h1022FFFF || memAddr !== 8'd0) begin
      failures++;
      $display("FAIL beq_write: got we=%b data=%h addr=%0d, want 1 1022FFFF 0", memWriteEn, memData, memAddr);
    end
    // Back-to-back: sw is presented while busy and taken on the next IDLE edge.
    setFields(2'b10, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'hFFFF, 1'b0);
    tick();
    checks++;
    if (memWriteEn !== 1'b0 || inReady !== 1'b1 || memData !== 32'd0) begin
      failures++;
      $display("FAIL beq_gap: got we=%b inReady=%b data=%h, want 0 1 0", memWriteEn, inReady, memData);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if (memWriteEn !== 1'b1 || memData !== 32'hAC22FFFF || memAddr !== 8'd1) begin
      failures++;
      $display("FAIL sw_write: got we=%b data=%h addr=%0d, want 1 AC22FFFF 1", memWriteEn, memData, memAddr);
    end
    tick();
    checks++;
    if (count !== 9'd2 || memAddr !== 8'd2) begin
      failures++;
      $display("FAIL sw_count: got count=%0d addr=%0d, want 2 2", count, memAddr);
    end
  endtask

  task automatic test_full();
    logic [8:0] expAddr;
    int writes;
    doReset();
    expAddr = 9'd0;
    writes  = 0;
    setFields(2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
    inValid = 1'b1;
    for (int cyc = 0; cyc < 700 && full !== 1'b1; cyc++) begin
      tick();
      if (memWriteEn === 1'b1) begin
        checks++;
        if (memAddr !== expAddr[7:0] || memData !== {16'h8C00, 7'd0, expAddr}) begin
          failures++;
          $display("FAIL full_seq: got addr=%0d data=%h, want %0d %h", memAddr, memData, expAddr[7:0], {16'h8C00, 7'd0, expAddr});
        end
        writes++;
        expAddr = expAddr + 9'd1;
        imm = {7'd0, expAddr};
      end
    end
    checks++;
    if (writes != 256 || count !== 9'd256 || full !== 1'b1 || done !== 1'b0 || memAddr !== 8'd255 || inReady !== 1'b0) begin
      failures++;
      $display("FAIL full_end: got writes=%0d count=%0d full=%b done=%b addr=%0d inReady=%b, want 256 256 1 0 255 0",
               writes, count, full, done, memAddr, inReady);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (memWriteEn !== 1'b0 || inReady !== 1'b0 || memAddr !== 8'd255 || full !== 1'b1) begin
        failures++;
        $display("FAIL full_hold: cycle %0d got we=%b inReady=%b addr=%0d full=%b, want 0 0 255 1", i, memWriteEn, inReady, memAddr, full);
      end
    end
    inValid = 1'b0;
  endtask

  task automatic test_restart_accept();
    doReset();
    setFields(2'b00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'd0, 1'b0);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    // Now IDLE at address 1; restart and inValid arrive together.
    inValid = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (memWriteEn !== 1'b0 || memAddr !== 8'd0 || count !== 9'd0 || inReady !== 1'b1) begin
      failures++;
      $display("FAIL restart_drop: got we=%b addr=%0d count=%0d inReady=%b, want 0 0 0 1", memWriteEn, memAddr, count, inReady);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if (memWriteEn !== 1'b1 || memAddr !== 8'd0 || memData !== 32'h00221820) begin
      failures++;
      $display("FAIL restart_next: got we=%b addr=%0d data=%h, want 1 0 00221820", memWriteEn, memAddr, memData);
    end
    tick();
  endtask

  task automatic test_restart_in_write();
    doReset();
    setFields(2'b01, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 1'b1);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    restart = 1'b1;
    checks++;
    if (memWriteEn !== 1'b1 || memData !== 32'h8D280004) begin
      failures++;
      $display("FAIL restart_write: got we=%b data=%h, want 1 8D280004", memWriteEn, memData);
    end
    tick();
    restart = 1'b0;
    checks++;
    if (memWriteEn !== 1'b0 || count !== 9'd0 || memAddr !== 8'd0 || done !== 1'b0 || inReady !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear: got we=%b count=%0d addr=%0d done=%b inReady=%b, want 0 0 0 0 1",
               memWriteEn, count, memAddr, done, inReady);
    end
  endtask

  task automatic test_reset_in_write();
    doReset();
    setFields(2'b10, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b0);
    inValid = 1'b1;
    tick();
    checks++;
    if (memWriteEn !== 1'b1) begin
      failures++;
      $display("FAIL rstw_pre: got we=%b, want 1", memWriteEn);
    end
    reset   = 1'b1;
    restart = 1'b1;
    tick();
    checks++;
    if ({inReady, memWriteEn, memAddr, memData, count, done, full} !== {1'b1, 1'b0, 8'd0, 32'd0, 9'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rstw_state: got inReady=%b we=%b addr=%0d data=%h count=%0d done=%b full=%b, want 1 0 0 0 0 0 0",
               inReady, memWriteEn, memAddr, memData, count, done, full);
    end
    reset   = 1'b0;
    restart = 1'b0;
    inValid = 1'b0;
    tick();
    checks++;
    if (memWriteEn !== 1'b0 || count !== 9'd0 || inReady !== 1'b1) begin
      failures++;
      $display("FAIL rstw_after: got we=%b count=%0d inReady=%b, want 0 0 1", memWriteEn, count, inReady);
    end
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; restart = 1'b0;
    setFields(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
    tick();
    test_reset();
    test_rtype();
    test_lw_last();
    test_beq_sw();
    test_full();
    test_restart_accept();
    test_restart_in_write();
    test_reset_in_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
